// File: rtl/trap_if.sv
// Trap unit bus: MEM-stage events and CSR views in, CSR commit strobes and fetch redirect out.
interface trap_if;
  logic        valid_mem;
  logic [31:0] pc_mem;
  logic [31:0] inst_mem;
  logic [31:0] addr_mem;
  logic        illegal_inst;
  logic        ecall;
  logic        l_fault;
  logic        s_fault;
  logic        mret;
  logic        irq_ext;
  logic [31:0] mstatus;
  logic [31:0] mtvec;
  logic [31:0] mepc_in;
  logic        is_trap;
  logic        is_mret;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] mtval;
  logic        flush;
  logic        busy;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  // Pipeline/CSR side
  modport master (
    output valid_mem, pc_mem, inst_mem, addr_mem, illegal_inst, ecall, l_fault,
           s_fault, mret, irq_ext, mstatus, mtvec, mepc_in, redirect_ready,
    input  is_trap, is_mret, mepc, mcause, mtval, flush, busy, redirect_valid, redirect_pc
  );

  // Trap unit side
  modport slave (
    input  valid_mem, pc_mem, inst_mem, addr_mem, illegal_inst, ecall, l_fault,
           s_fault, mret, irq_ext, mstatus, mtvec, mepc_in, redirect_ready,
    output is_trap, is_mret, mepc, mcause, mtval, flush, busy, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/trap_unit.sv
// Machine-mode trap/mret sequencer: prioritises MEM-stage events, commits CSR updates
// for one cycle, then holds a fetch redirect until it is accepted.
module trap_unit #(
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  trap_if.slave bus
);

  typedef enum logic [1:0] {IDLE, TRAP, RET, REDIRECT} state_t;

  state_t      state, state_nxt;
  logic        irq_pending;
  logic [31:0] mepc_q, mcause_q, mtval_q, target_q;

  logic        int_take, int_entry;
  logic        take_trap, take_mret;
  logic [31:0] cause_d, tval_d, target_d, tvec_base;

  // Only MIE participates; the remaining mstatus bits are irrelevant here.
  logic unused_mstatus;
  assign unused_mstatus = ^{bus.mstatus[31:4], bus.mstatus[2:0]};

  assign int_take  = irq_pending & bus.mstatus[3];
  assign tvec_base = {bus.mtvec[31:2], 2'b00};

  // Event selection; only an IDLE cycle with a valid MEM instruction can start anything.
  always_comb begin
    take_trap = 1'b0;
    take_mret = 1'b0;
    int_entry = 1'b0;
    cause_d   = '0;
    tval_d    = '0;
    if (state == IDLE && bus.valid_mem) begin
      if (int_take) begin
        take_trap = 1'b1;
        int_entry = 1'b1;
        cause_d   = 32'h8000_000B;
      end else if (bus.illegal_inst) begin
        take_trap = 1'b1;
        cause_d   = 32'd2;
        tval_d    = bus.inst_mem;
      end else if (bus.ecall) begin
        take_trap = 1'b1;
        cause_d   = 32'd11;
      end else if (bus.l_fault) begin
        take_trap = 1'b1;
        cause_d   = 32'd5;
        tval_d    = bus.addr_mem;
      end else if (bus.s_fault) begin
        take_trap = 1'b1;
        cause_d   = 32'd7;
        tval_d    = bus.addr_mem;
      end else if (bus.mret) begin
        take_mret = 1'b1;
      end
    end
  end

  // Vectored offset is 4*cause[30:0] truncated to 32 bits, i.e. cause[29:0] << 2.
  always_comb begin
    target_d = tvec_base;
    if (take_mret)
      target_d = bus.mepc_in;
    else if (VECTORED_EN && bus.mtvec[1:0] == 2'b01 && cause_d[31])
      target_d = tvec_base + {cause_d[29:0], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      irq_pending <= 1'b0;
      mepc_q      <= '0;
      mcause_q    <= '0;
      mtval_q     <= '0;
      target_q    <= '0;
    end else begin
      state       <= state_nxt;
      irq_pending <= int_entry ? 1'b0 : (irq_pending | bus.irq_ext);
      if (take_trap || take_mret) begin
        mepc_q   <= bus.pc_mem;
        mcause_q <= cause_d;
        mtval_q  <= tval_d;
        target_q <= target_d;
      end
    end
  end

  always_comb begin
    state_nxt          = state;
    bus.is_trap        = 1'b0;
    bus.is_mret        = 1'b0;
    bus.flush          = 1'b0;
    bus.mepc           = '0;
    bus.mcause         = '0;
    bus.mtval          = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.busy           = (state != IDLE);
    case (state)
      IDLE: begin
        bus.flush = take_trap | take_mret;
        if (take_trap)      state_nxt = TRAP;
        else if (take_mret) state_nxt = RET;
      end
      TRAP: begin
        bus.is_trap = 1'b1;
        bus.flush   = 1'b1;
        bus.mepc    = mepc_q;
        bus.mcause  = mcause_q;
        bus.mtval   = mtval_q;
        state_nxt   = REDIRECT;
      end
      RET: begin
        bus.is_mret = 1'b1;
        bus.flush   = 1'b1;
        bus.mepc    = bus.mepc_in;
        state_nxt   = REDIRECT;
      end
      REDIRECT: begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target_q;
        bus.flush          = 1'b1;
        if (bus.redirect_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
